// File: rtl/alu_reg16.sv
// alu_reg16: registered 16-operation ALU, used as a single-cycle execute stage.
// The result is computed combinationally from sel/A/B and captured on every rising clock
// edge. There is no handshake, so a new operation is accepted every cycle.
//
// Ports:
//   clk  in   1         clock; all state updates on the rising edge
//   rst  in   1         synchronous, active-low reset; clears Z
//   sel  in   4         opcode
//   A    in   DATA_W    operand A (unsigned)
//   B    in   DATA_W    operand B (unsigned)
//   Z    out  2*DATA_W  registered result
module alu_reg16 #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            sel,
  input  logic [DATA_W-1:0]     A,
  input  logic [DATA_W-1:0]     B,
  output logic [2*DATA_W-1:0]   Z
);

  localparam int unsigned ZW = 2 * DATA_W;

  logic [ZW-1:0]     a_ext;
  logic [ZW-1:0]     b_ext;
  logic [DATA_W-1:0] hi_zero;
  logic [ZW-1:0]     z_d;
  logic [ZW-1:0]     z_q;

  assign hi_zero = '0;
  assign a_ext   = {hi_zero, A};
  assign b_ext   = {hi_zero, B};

  // Operands are zero-extended first so carries, borrows, the product and the bit shifted
  // out by opcode 4 all land naturally in the upper byte.
  always_comb begin
    z_d = '0;
    case (sel)
      4'h0: z_d = a_ext + b_ext;
      4'h1: z_d = a_ext - b_ext;  // wraps to 16-bit two's complement on borrow
      4'h2: z_d = a_ext * b_ext;
      4'h3: z_d = (B == '0) ? '1 : (a_ext / b_ext);
      4'h4: z_d = a_ext << 1;
      4'h5: z_d = a_ext >> 1;
      4'h6: z_d = a_ext & b_ext;
      4'h7: z_d = a_ext | b_ext;
      4'h8: z_d = a_ext ^ b_ext;
      4'h9: z_d = {hi_zero, ~(A & B)};
      4'hA: z_d = {hi_zero, ~(A | B)};
      4'hB: z_d = {hi_zero, ~(A ^ B)};
      4'hC: z_d = {hi_zero, A[DATA_W-2:0], A[DATA_W-1]};
      4'hD: z_d = {hi_zero, A[0], A[DATA_W-1:1]};
      4'hE: z_d = {{(ZW-1){1'b0}}, (A > B)};
      4'hF: z_d = {{(ZW-1){1'b0}}, (A == B)};
      default: z_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_alu_reg16.sv
// Directed bench for alu_reg16. Inputs change just after the falling edge; Z is checked
// 1 time unit after that (must still hold the previous result) and 1 time unit after the
// next rising edge (must show the new result).
module tb_alu_reg16;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] Z;

  int unsigned checks;
  int unsigned errors;
  logic [15:0] prev_z;

  alu_reg16 #(.DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .sel (sel),
    .A   (A),
    .B   (B),
    .Z   (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (Z === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, Z, exp);
    end
  endtask

  // One operation: results must not appear before the edge, and must appear right after it.
  task automatic op(input string tag, input logic [3:0] s, input logic [7:0] a,
                    input logic [7:0] b, input logic [15:0] exp);
    @(negedge clk);
    sel = s;
    A   = a;
    B   = b;
    #1;
    check({tag, "_hold"}, prev_z);
    @(posedge clk);
    #1;
    check(tag, exp);
    prev_z = exp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    sel = 4'h0;
    A   = 8'hFF;
    B   = 8'hFF;

    // Reset holds Z at zero despite live operands.
    @(posedge clk); #1; check("rst_edge1", 16'h0000);
    @(posedge clk); #1; check("rst_edge2", 16'h0000);
    prev_z = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    #1; check("rst_release_hold", 16'h0000);
    @(posedge clk); #1; check("rst_release", 16'h01FE);
    prev_z = 16'h01FE;

    // Add / sub
    op("add_carry",  4'h0, 8'd255, 8'd10,  16'h0109);
    op("add_zero",   4'h0, 8'd0,   8'd0,   16'h0000);
    op("sub_pos",    4'h1, 8'd10,  8'd5,   16'h0005);
    op("sub_borrow", 4'h1, 8'd10,  8'd255, 16'hFF0B);
    // Mul / div
    op("mul",        4'h2, 8'd15,  8'd20,  16'h012C);
    op("mul_max",    4'h2, 8'd255, 8'd255, 16'hFE01);
    op("div",        4'h3, 8'd255, 8'd10,  16'h0019);
    op("div_zero",   4'h3, 8'd37,  8'd0,   16'hFFFF);
    // Logic
    op("and",        4'h6, 8'h0F, 8'hAA, 16'h000A);
    op("or",         4'h7, 8'h0F, 8'hAA, 16'h00AF);
    op("xor",        4'h8, 8'h0F, 8'hAA, 16'h00A5);
    op("nand",       4'h9, 8'h0F, 8'hAA, 16'h00F5);
    op("nor",        4'hA, 8'h0F, 8'hAA, 16'h0050);
    op("xnor",       4'hB, 8'h0F, 8'hAA, 16'h005A);
    // Shift / rotate (B must be ignored)
    op("shl",        4'h4, 8'd255, 8'h00, 16'h01FE);
    op("shl_bign",   4'h4, 8'h41,  8'hFF, 16'h0082);
    op("shr",        4'h5, 8'd255, 8'h3C, 16'h007F);
    op("rol",        4'hC, 8'h81,  8'h55, 16'h0003);
    op("ror",        4'hD, 8'h81,  8'hAA, 16'h00C0);
    // Compare
    op("gt_true",    4'hE, 8'd10, 8'd5,  16'h0001);
    op("gt_false",   4'hE, 8'd5,  8'd10, 16'h0000);
    op("gt_equal",   4'hE, 8'd7,  8'd7,  16'h0000);
    op("eq_true",    4'hF, 8'd10, 8'd10, 16'h0001);
    op("eq_false",   4'hF, 8'd10, 8'd5,  16'h0000);

    // Back-to-back: hold Z across a cycle with unchanged inputs
    op("mul_again",  4'h2, 8'd15, 8'd20, 16'h012C);
    @(negedge clk); #1; check("stable_mid", 16'h012C);

    // Mid-stream reset clears on the next edge and holds while low
    @(negedge clk);
    rst = 1'b0;
    sel = 4'h0;
    A   = 8'hFF;
    B   = 8'h01;
    #1; check("mid_rst_hold", 16'h012C);
    @(posedge clk); #1; check("mid_rst_clear", 16'h0000);
    @(posedge clk); #1; check("mid_rst_stay", 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; check("post_rst_add", 16'h0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
